// File: rtl/function_serial_tx_pkg.sv
// Shared types and helpers for the framed serial transmitter.
package function_serial_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic IDLE_LEVEL   = 1'b1;
  localparam int   PARITY_MAX_W = 64;

  // Even parity: words up to PARITY_MAX_W bits wide are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/function_serial_tx_bit_timer.sv
// Per-bit cycle counter; tick marks the last cycle of each serial bit.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign tick = (r_count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/function_serial_tx.sv
// Parallel-to-serial framed transmitter: start bit, data LSB first, optional even parity, stop bit.
module function_serial_tx
  import function_serial_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_stateNext;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_bitIdx;
  logic              r_parity;
  logic              r_tx;
  logic              r_inReady;
  logic              r_busy;
  logic              r_frameDone;
  logic              w_tick;
  logic              w_accept;
  logic              w_lastBit;

  assign w_accept  = in_valid & r_inReady;
  assign w_lastBit = (r_bitIdx == LAST_IDX);

  // Timer is held at zero while idle so every frame starts on a fresh bit period.
  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(r_state == IDLE),
    .tick (w_tick)
  );

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = START;
      START:   if (w_tick) w_stateNext = DATA;
      DATA:    if (w_tick && w_lastBit) w_stateNext = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (w_tick) w_stateNext = STOP;
      STOP:    if (w_tick) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitIdx    <= '0;
      r_parity    <= 1'b0;
      r_tx        <= IDLE_LEVEL;
      r_inReady   <= 1'b1;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_inReady   <= (w_stateNext == IDLE);
      r_busy      <= (w_stateNext != IDLE);
      r_frameDone <= (r_state == STOP) && w_tick;
      if (w_accept) begin
        r_shift  <= in_data;
        r_parity <= parity_of(PARITY_MAX_W'(in_data));
        r_bitIdx <= '0;
        r_tx     <= 1'b0;
      end else if (w_tick) begin
        // The line only moves on a bit boundary; the shifter always presents the next data bit at [0].
        case (r_state)
          START: begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          DATA: begin
            if (w_lastBit) begin
              r_tx <= (PARITY_EN != 0) ? r_parity : IDLE_LEVEL;
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end
          PARITY:  r_tx <= IDLE_LEVEL;
          STOP:    r_tx <= IDLE_LEVEL;
          default: ;
        endcase
      end
    end
  end

  assign tx         = r_tx;
  assign in_ready   = r_inReady;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_function_serial_tx.sv
// Directed bench for function_serial_tx across three parameterisations (parity, no parity, one-cycle bits).
module tb_function_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] inValid;
  logic [7:0] inData [3];
  wire  [2:0] inReady;
  wire  [2:0] txLine;
  wire  [2:0] busyLine;
  wire  [2:0] doneLine;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function_serial_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1)) dutPar (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
    .tx(txLine[0]), .busy(busyLine[0]), .frame_done(doneLine[0])
  );

  function_serial_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(0)) dutNoPar (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
    .tx(txLine[1]), .busy(busyLine[1]), .frame_done(doneLine[1])
  );

  function_serial_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1)) dutFast (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
    .tx(txLine[2]), .busy(busyLine[2]), .frame_done(doneLine[2])
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one frame on instance sel and checks it cycle by cycle; chain keeps in_valid high to offer nextData.
  task automatic applyStimulus(input int sel, input logic [7:0] data, input logic expPar, input int bc,
                               input bit pe, input bit offered, input bit chain,
                               input logic [7:0] nextData, input string name);
    logic [10:0] frame;
    int nBits;
    int frameLen;
    nBits = pe ? 11 : 10;
    frame = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = data[i];
    if (pe) frame[9] = expPar;
    frame[nBits-1] = 1'b1;
    frameLen = nBits * bc;
    if (!offered) begin
      inValid[sel] = 1'b1;
      inData[sel]  = data;
      @(negedge clk);
    end
    if (!chain) inValid[sel] = 1'b0;
    for (int k = 0; k < frameLen; k++) begin
      if (k == 0) begin
        checkOutput($sformatf("%s busy at start", name), busyLine[sel], 1'b1);
        checkOutput($sformatf("%s ready at start", name), inReady[sel], 1'b0);
      end
      checkOutput($sformatf("%s tx k=%0d", name, k), txLine[sel], frame[k/bc]);
      checkOutput($sformatf("%s early done k=%0d", name, k), doneLine[sel], 1'b0);
      if (chain) begin
        inData[sel] = (k % 2 == 0) ? 8'h00 : 8'hAA;
      end else begin
        inData[sel] = ~data;
        if (k == 5) begin
          inValid[sel] = 1'b1;
          inData[sel]  = 8'h00;
        end
        if (k == 7) inValid[sel] = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s done pulse", name), doneLine[sel], 1'b1);
    checkOutput($sformatf("%s busy at done", name), busyLine[sel], 1'b0);
    checkOutput($sformatf("%s ready at done", name), inReady[sel], 1'b1);
    checkOutput($sformatf("%s tx at done", name), txLine[sel], 1'b1);
    if (chain) begin
      inData[sel] = nextData;
      @(negedge clk);
    end else begin
      @(negedge clk);
      checkOutput($sformatf("%s done one cycle", name), doneLine[sel], 1'b0);
      checkOutput($sformatf("%s tx idle after", name), txLine[sel], 1'b1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    inValid = '0;
    for (int i = 0; i < 3; i++) inData[i] = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset tx[%0d]", i), txLine[i], 1'b1);
      checkOutput($sformatf("reset ready[%0d]", i), inReady[i], 1'b1);
      checkOutput($sformatf("reset busy[%0d]", i), busyLine[i], 1'b0);
      checkOutput($sformatf("reset done[%0d]", i), doneLine[i], 1'b0);
    end
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("idle tx", txLine[0], 1'b1);
      checkOutput("idle ready", inReady[0], 1'b1);
      checkOutput("idle busy", busyLine[0], 1'b0);
      checkOutput("idle done", doneLine[0], 1'b0);
    end

    applyStimulus(0, 8'hA5, 1'b0, 4, 1'b1, 1'b0, 1'b0, 8'h00, "A5");
    applyStimulus(0, 8'h07, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'h00, "07par");
    applyStimulus(1, 8'h07, 1'b0, 4, 1'b0, 1'b0, 1'b0, 8'h00, "07nopar");

    applyStimulus(0, 8'h01, 1'b1, 4, 1'b1, 1'b0, 1'b1, 8'hFF, "b2b01");
    applyStimulus(0, 8'hFF, 1'b0, 4, 1'b1, 1'b1, 1'b0, 8'h00, "b2bFF");

    inValid[0] = 1'b1;
    inData[0]  = 8'h3C;
    @(negedge clk);
    inValid[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("3C busy k=%0d", k), busyLine[0], 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset tx", txLine[0], 1'b1);
    checkOutput("midreset ready", inReady[0], 1'b1);
    checkOutput("midreset busy", busyLine[0], 1'b0);
    checkOutput("midreset done", doneLine[0], 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput("post reset no done", doneLine[0], 1'b0);
      checkOutput("post reset tx", txLine[0], 1'b1);
    end
    applyStimulus(0, 8'h80, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'h00, "80");

    rst        = 1'b1;
    inValid[0] = 1'b1;
    inData[0]  = 8'h55;
    @(negedge clk);
    rst        = 1'b0;
    inValid[0] = 1'b0;
    checkOutput("rst+valid busy", busyLine[0], 1'b0);
    checkOutput("rst+valid ready", inReady[0], 1'b1);
    checkOutput("rst+valid tx", txLine[0], 1'b1);
    @(negedge clk);
    checkOutput("rst+valid still idle", busyLine[0], 1'b0);
    checkOutput("rst+valid tx later", txLine[0], 1'b1);

    applyStimulus(2, 8'hC3, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h00, "C3fast");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
